hyper_chan_select: RTL
======================

HYPER_CHAN_SELECT -- requirements
Module: hyper_chan_select

Interface
REQ-001 SHALL have parameter ONEHOT_WIDTH, default 16, number of channels (2..64).
REQ-002 SHALL have parameter BIN_WIDTH, default $clog2(ONEHOT_WIDTH), channel index width, not to be overridden.
REQ-003 SHALL have parameter LEN_WIDTH, default 16, burst-length field width.
REQ-004 clk_i  input  1  single clock; all state changes on the rising edge.
REQ-005 rst_i  input  1  reset, synchronous, active-high.
REQ-006 req_valid_i  input  1  request valid.
REQ-007 req_ready_o  output  1  request accepted when req_valid_i and req_ready_o are both high.
REQ-008 req_bin_i  input  BIN_WIDTH  binary channel index.
REQ-009 req_len_i  input  LEN_WIDTH  burst length minus one; 0 = 1 beat.
REQ-010 beat_i  input  1  one data beat transferred on the selected channel this cycle.
REQ-011 sel_o  output  ONEHOT_WIDTH  registered one-hot channel select.
REQ-012 busy_o  output  1  high while a burst is in progress.
REQ-013 done_o  output  1  single-cycle burst-complete pulse.
REQ-014 err_o  output  1  single-cycle pulse on an out-of-range index.

Function
REQ-015 SHALL implement FSM states IDLE, ACTIVE, DONE.
REQ-016 req_ready_o SHALL be high only in IDLE (combinational from state, not from req_valid_i).
REQ-017 IDLE, valid index (req_bin_i < ONEHOT_WIDTH) accepted: SHALL latch index and req_len_i, enter ACTIVE next cycle; sel_o bit [req_bin_i] high from that cycle; latency 1 cycle.
REQ-018 IDLE, req_bin_i >= ONEHOT_WIDTH accepted: SHALL assert err_o for exactly 1 cycle, keep sel_o zero, and remain in IDLE.
REQ-019 ACTIVE: a beat counter SHALL start at 0 and increment on each beat_i; when beat_i arrives with counter == latched length, SHALL go to DONE.
REQ-020 sel_o SHALL have exactly one bit set in ACTIVE and SHALL be all zero in IDLE and DONE.
REQ-021 busy_o SHALL be high in ACTIVE and DONE.
REQ-022 DONE SHALL last exactly 1 cycle with done_o high, then return to IDLE.
REQ-023 beat_i in IDLE or DONE SHALL be ignored (no count, no error).
REQ-024 req_valid_i outside IDLE SHALL be held off via req_ready_o low; the request is neither lost nor latched.
REQ-025 A new request SHALL be accepted no earlier than the cycle after DONE (minimum 3 cycles between accepts for a 1-beat burst).
REQ-026 Length counter SHALL be LEN_WIDTH bits; req_len_i all-ones SHALL yield 2^LEN_WIDTH beats without wrap-induced early termination.

Reset
REQ-027 rst_i high SHALL, on the next rising edge, force IDLE, clear counter and latched fields, and set outputs: sel_o=0, busy_o=0, done_o=0, err_o=0, req_ready_o=1 after release.
REQ-028 Reset asserted mid-burst SHALL abort the burst with no done_o pulse.

Structure
REQ-029 State enum and the LEN_WIDTH default SHALL live in shared package hyper_chan_select_pkg.
REQ-030 Index-to-one-hot decode SHALL be a combinational sub-module bin_to_onehot_hyper (BIN_WIDTH in, ONEHOT_WIDTH out, zero output for out-of-range index); sel_o register in the parent.
REQ-031 Expected RTL size: 120-250 lines including sub-module.

Verification
REQ-032 Reset then idle: req_valid_i=0 for 5 cycles -> sel_o=0, busy_o=0, req_ready_o=1.
REQ-033 Single beat: bin=5, len=0 accepted at cycle T, beat_i at T+2 -> sel_o=16'h0020 at T+1..T+2, done_o=1 at T+3 only, req_ready_o=1 at T+4.
REQ-034 Multi-beat with gaps: bin=15, len=3, beats on 4 non-consecutive cycles -> sel_o=16'h8000 throughout, done_o exactly once, after the 4th beat.
REQ-035 Back-pressure: second request held valid during a burst -> req_ready_o=0 until IDLE, then accepted once with its own index.
REQ-036 Out of range: ONEHOT_WIDTH=12, bin=13 -> err_o 1 cycle, sel_o=0, busy_o=0; a following bin=2 request is served normally.
REQ-037 Reset mid-burst: rst_i during ACTIVE at beat 2 of 4 -> next cycle sel_o=0, busy_o=0, no done_o.

Source files
------------

// File: rtl/hyper_chan_select_pkg.sv
// ----------------------------------------------------------------------------
// hyper_chan_select_pkg
// Shared definitions for the hyper_chan_select channel-select block:
//   - hyper_chan_state_e : controller state encoding (IDLE / ACTIVE / DONE)
//   - LEN_WIDTH_DEFAULT  : default width of the burst-length field
//   - ONEHOT_WIDTH_DEFAULT : default number of channels
//   - is_busy_state()    : states in which a burst is considered in progress
// ----------------------------------------------------------------------------
package hyper_chan_select_pkg;

    localparam int ONEHOT_WIDTH_DEFAULT = 16;
    localparam int LEN_WIDTH_DEFAULT    = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        DONE   = 2'd2
    } hyper_chan_state_e;

    // A burst occupies the channel from the first ACTIVE cycle through the
    // single DONE cycle; only IDLE is free.
    function automatic logic is_busy_state(input hyper_chan_state_e s);
        return (s == ACTIVE) || (s == DONE);
    endfunction

endpackage : hyper_chan_select_pkg

// File: rtl/hyper_chan_select_decode.sv
// ----------------------------------------------------------------------------
// bin_to_onehot_hyper
// Purely combinational binary-index to one-hot decoder.
//   bin_i    [BIN_WIDTH-1:0]    : binary channel index
//   onehot_o [ONEHOT_WIDTH-1:0] : one-hot decode; all zero when
//                                 bin_i >= ONEHOT_WIDTH
// The all-zero output for out-of-range indices doubles as the range check
// in the parent (an index is valid exactly when the decode is non-zero).
// ----------------------------------------------------------------------------
module bin_to_onehot_hyper #(
    parameter int ONEHOT_WIDTH = 16,
    parameter int BIN_WIDTH    = $clog2(ONEHOT_WIDTH)
) (
    input  logic [BIN_WIDTH-1:0]    bin_i,
    output logic [ONEHOT_WIDTH-1:0] onehot_o
);

    always_comb begin
        onehot_o = '0;
        for (int i = 0; i < ONEHOT_WIDTH; i++) begin
            if (bin_i == BIN_WIDTH'(i)) begin
                onehot_o[i] = 1'b1;
            end
        end
    end

endmodule : bin_to_onehot_hyper

// File: rtl/hyper_chan_select.sv
// ----------------------------------------------------------------------------
// hyper_chan_select
// Accepts a (channel index, burst length) request, drives a registered
// one-hot channel select for the duration of the burst, counts data beats
// and signals completion.
//
// Ports:
//   clk_i        : clock, all state changes on the rising edge
//   rst_i        : synchronous active-high reset
//   req_valid_i  : request valid
//   req_ready_o  : request ready (high only in IDLE)
//   req_bin_i    : binary channel index
//   req_len_i    : burst length minus one (0 = 1 beat)
//   beat_i       : one data beat on the selected channel this cycle
//   sel_o        : registered one-hot channel select (non-zero only in ACTIVE)
//   busy_o       : burst in progress (ACTIVE or DONE)
//   done_o       : one-cycle burst-complete pulse (the DONE cycle)
//   err_o        : one-cycle pulse after an out-of-range index is accepted
//   state_o      : current controller state, for observation
//
// Handshake: a request transfers on a rising edge where req_valid_i and
// req_ready_o are both high. req_ready_o depends only on the state, never on
// req_valid_i; a requester holding req_valid_i while ready is low keeps its
// request until it is taken.
// ----------------------------------------------------------------------------
module hyper_chan_select
    import hyper_chan_select_pkg::*;
#(
    parameter int ONEHOT_WIDTH = ONEHOT_WIDTH_DEFAULT,
    parameter int BIN_WIDTH    = $clog2(ONEHOT_WIDTH),
    parameter int LEN_WIDTH    = LEN_WIDTH_DEFAULT
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    req_valid_i,
    output logic                    req_ready_o,
    input  logic [BIN_WIDTH-1:0]    req_bin_i,
    input  logic [LEN_WIDTH-1:0]    req_len_i,
    input  logic                    beat_i,
    output logic [ONEHOT_WIDTH-1:0] sel_o,
    output logic                    busy_o,
    output logic                    done_o,
    output logic                    err_o,
    output hyper_chan_state_e       state_o
);

    hyper_chan_state_e       state_q, state_d;
    logic [ONEHOT_WIDTH-1:0] sel_q,   sel_d;
    logic [LEN_WIDTH-1:0]    len_q,   len_d;
    logic [LEN_WIDTH-1:0]    cnt_q,   cnt_d;
    logic                    err_q,   err_d;

    logic [ONEHOT_WIDTH-1:0] dec_onehot;
    logic                    idx_valid;
    logic                    req_fire;

    bin_to_onehot_hyper #(
        .ONEHOT_WIDTH (ONEHOT_WIDTH),
        .BIN_WIDTH    (BIN_WIDTH)
    ) u_decode (
        .bin_i    (req_bin_i),
        .onehot_o (dec_onehot)
    );

    assign idx_valid   = |dec_onehot;
    assign req_ready_o = (state_q == IDLE);
    assign req_fire    = req_valid_i && req_ready_o;

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        err_d   = 1'b0;

        case (state_q)
            IDLE: begin
                sel_d = '0;
                cnt_d = '0;
                if (req_fire) begin
                    if (idx_valid) begin
                        state_d = ACTIVE;
                        sel_d   = dec_onehot;
                        len_d   = req_len_i;
                    end else begin
                        // Bad index: report it and stay free for the next request.
                        err_d = 1'b1;
                    end
                end
            end

            ACTIVE: begin
                if (beat_i) begin
                    // Compare before incrementing so an all-ones length
                    // terminates on the last beat instead of wrapping.
                    if (cnt_q == len_q) begin
                        state_d = DONE;
                        sel_d   = '0;
                    end else begin
                        cnt_d = cnt_q + LEN_WIDTH'(1);
                    end
                end
            end

            DONE: begin
                state_d = IDLE;
                sel_d   = '0;
                cnt_d   = '0;
            end

            default: begin
                state_d = IDLE;
                sel_d   = '0;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            sel_q   <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    assign sel_o   = sel_q;
    assign busy_o  = is_busy_state(state_q);
    assign done_o  = (state_q == DONE);
    assign err_o   = err_q;
    assign state_o = state_q;

endmodule : hyper_chan_select
